// File: rtl/mic_stream_scheduler.sv
// Round-robin merge of four mic deserializer lanes into one tagged 32-bit stream.
// Each lane has a one-deep hold register. Output words are {ch, frame_cnt, sample}.
module mic_stream_scheduler #(
  parameter int SAMPLE_W = 24,
  parameter int OVF_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    frame_start,
  input  logic [3:0]              cfg_en,
  input  logic [3:0]              ch_valid,
  input  logic [4*SAMPLE_W-1:0]   ch_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_data,
  output logic [OVF_W-1:0]        ovf_count,
  input  logic                    cnt_clr
);

  // Handshake: a word transfers on any rising edge where out_valid & out_ready.
  // While out_valid is high and out_ready is low, out_data stays unchanged.

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_nxt;
  logic [3:0]          pending, pending_nxt;
  logic [3:0]          cand, grant_vec, strobe, drop, load;
  logic [SAMPLE_W-1:0] hold [4];
  logic [SAMPLE_W-1:0] hold_sel;
  logic [23:0]         sample_ext;
  logic [1:0]          rr_ptr, winner, scan_idx;
  logic                found, grant;
  logic [5:0]          frame_cnt;
  logic [2:0]          drop_cnt;
  logic [OVF_W+2:0]    ovf_sum;
  logic [OVF_W-1:0]    ovf_nxt;

  assign cand      = pending & cfg_en;
  assign out_valid = (state == SEND);

  // First candidate at or after rr_ptr, wrapping modulo 4.
  always_comb begin
    winner   = rr_ptr;
    found    = 1'b0;
    scan_idx = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr_ptr + k[1:0];
      if (!found && cand[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (|cand) begin
          grant     = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (|cand) grant = 1'b1;
          else       state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A lane granted this edge frees its hold register, so a new strobe may refill it.
  always_comb begin
    grant_vec   = grant ? (4'b0001 << winner) : 4'b0000;
    strobe      = ch_valid & cfg_en;
    drop        = strobe & pending & ~grant_vec;
    load        = strobe & ~drop;
    pending_nxt = cfg_en & (load | (pending & ~grant_vec));
  end

  always_comb begin
    hold_sel   = hold[winner];
    sample_ext = {24{hold_sel[SAMPLE_W-1]}};
    sample_ext[SAMPLE_W-1:0] = hold_sel;
  end

  always_comb begin
    drop_cnt = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
    ovf_sum  = {3'b000, ovf_count} + (OVF_W+3)'(drop_cnt);
    if (ovf_sum > {3'b000, {OVF_W{1'b1}}}) ovf_nxt = {OVF_W{1'b1}};
    else                                   ovf_nxt = ovf_sum[OVF_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      ovf_count <= '0;
      pending   <= '0;
      rr_ptr    <= '0;
      frame_cnt <= '0;
      for (int i = 0; i < 4; i++) hold[i] <= '0;
    end else begin
      if (grant) begin
        out_data <= {winner, frame_cnt, sample_ext};
        rr_ptr   <= winner + 2'd1;
      end
      pending <= pending_nxt;
      for (int i = 0; i < 4; i++) begin
        if (load[i]) hold[i] <= ch_data[i*SAMPLE_W +: SAMPLE_W];
      end
      if (frame_start) frame_cnt <= frame_cnt + 6'd1;
      if (cnt_clr) ovf_count <= '0;
      else         ovf_count <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_mic_stream_scheduler.sv
// Directed bench for mic_stream_scheduler with 16-bit lanes and hand-computed expected words.
module tb_mic_stream_scheduler;

  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_start = 1'b0;
  logic [3:0]    cfg_en = 4'h0;
  logic [3:0]    ch_valid = 4'h0;
  logic [4*SW-1:0] ch_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic [7:0]    ovf_count;
  logic          cnt_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  mic_stream_scheduler #(.SAMPLE_W(SW), .OVF_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .cfg_en(cfg_en),
    .ch_valid(ch_valid), .ch_data(ch_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .ovf_count(ovf_count), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [SW-1:0] v);
    ch_data[i*SW +: SW] = v;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || ovf_count !== 8'h0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b data=%h ovf=%0d, required 0/0/0",
               out_valid, out_data, ovf_count);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_all_lanes();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h00000011; exp_w[1] = 32'h40000022;
    exp_w[2] = 32'h80000033; exp_w[3] = 32'hC0000044;
    cfg_en = 4'hF; out_ready = 1'b1;
    set_lane(0, 16'h0011); set_lane(1, 16'h0022);
    set_lane(2, 16'h0033); set_lane(3, 16'h0044);
    ch_valid = 4'hF;
    tick();
    ch_valid = 4'h0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got valid=%b one cycle after strobe, required 0", out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_w[k]) begin
        errors++;
        $display("FAIL all_lanes_word%0d: got valid=%b data=%h, required 1 %h",
                 k, out_valid, out_data, exp_w[k]);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL all_lanes_idle: got valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_lane(1, 16'h0123); ch_valid = 4'h2;
    tick();
    set_lane(1, 16'h0456);
    tick();
    set_lane(1, 16'h0789);
    tick();
    ch_valid = 4'h0;
    checks++;
    if (ovf_count !== 8'd1 || out_valid !== 1'b1 || out_data !== 32'h40000123) begin
      errors++;
      $display("FAIL overrun_drop: got ovf=%0d valid=%b data=%h, required 1 1 40000123",
               ovf_count, out_valid, out_data);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h40000123) begin
        errors++;
        $display("FAIL stall_stable%0d: got valid=%b data=%h, required 1 40000123",
                 k, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h40000456) begin
      errors++;
      $display("FAIL held_sample: got valid=%b data=%h, required 1 40000456", out_valid, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_idle: got valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_round_robin();
    int drained;
    set_lane(0, 16'h00AA); set_lane(2, 16'h00CC);
    ch_valid = 4'h5;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== ((k % 2 == 0) ? 32'h800000CC : 32'h000000AA)) begin
        errors++;
        $display("FAIL rr_word%0d: got valid=%b data=%h, required 1 %h", k, out_valid, out_data,
                 (k % 2 == 0) ? 32'h800000CC : 32'h000000AA);
      end
    end
    ch_valid = 4'h0;
    drained = 0;
    for (int k = 0; k < 8 && drained == 0; k++) begin
      tick();
      if (out_valid === 1'b0) drained = 1;
    end
    checks++;
    if (drained != 1) begin
      errors++;
      $display("FAIL rr_drain: got still valid after 8 cycles, required idle");
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (ovf_count !== 8'd0) begin
      errors++;
      $display("FAIL cnt_clr: got ovf=%0d, required 0", ovf_count);
    end
  endtask

  task automatic test_sign_and_frame();
    set_lane(3, 16'h8000); ch_valid = 4'h8;
    tick();
    ch_valid = 4'h0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hC0FF8000) begin
      errors++;
      $display("FAIL sign_extend: got valid=%b data=%h, required 1 C0FF8000", out_valid, out_data);
    end
    tick();
    frame_start = 1'b1;
    repeat (63) tick();
    frame_start = 1'b0;
    set_lane(0, 16'h7FFF); ch_valid = 4'h1;
    tick();
    ch_valid = 4'h0;
    tick();
    checks++;
    if (out_data !== 32'h3F007FFF) begin
      errors++;
      $display("FAIL frame_63: got data=%h, required 3F007FFF", out_data);
    end
    tick();
    set_lane(1, 16'h0001); ch_valid = 4'h2;
    tick();
    ch_valid = 4'h0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if (out_data !== 32'h7F000001) begin
      errors++;
      $display("FAIL frame_pre_increment: got data=%h, required 7F000001", out_data);
    end
    tick();
    set_lane(2, 16'h1234); ch_valid = 4'h4;
    tick();
    ch_valid = 4'h0;
    tick();
    checks++;
    if (out_data !== 32'h80001234) begin
      errors++;
      $display("FAIL frame_wrap: got data=%h, required 80001234", out_data);
    end
    tick();
  endtask

  task automatic test_disable_and_saturate();
    out_ready = 1'b0;
    set_lane(0, 16'h0050); ch_valid = 4'h1;
    tick();
    set_lane(3, 16'h0333); ch_valid = 4'h8;
    tick();
    ch_valid = 4'h0; cfg_en = 4'h7;
    tick();
    for (int n = 0; n <= 300; n++) begin
      set_lane(1, (n == 0) ? 16'h0111 : 16'h0999);
      ch_valid = 4'h2;
      tick();
      if (n == 100) begin
        checks++;
        if (ovf_count !== 8'd100) begin
          errors++;
          $display("FAIL ovf_count_100: got %0d, required 100", ovf_count);
        end
      end
    end
    ch_valid = 4'h0;
    checks++;
    if (ovf_count !== 8'd255) begin
      errors++;
      $display("FAIL ovf_saturate: got %0d, required 255", ovf_count);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h40000111) begin
      errors++;
      $display("FAIL after_disable_word: got valid=%b data=%h, required 1 40000111",
               out_valid, out_data);
    end
    tick();
    cfg_en = 4'hF;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL disabled_ch3_emitted%0d: got valid=%b data=%h, required valid 0",
                 k, out_valid, out_data);
      end
      tick();
    end
    out_ready = 1'b0;
    set_lane(1, 16'h0001); ch_valid = 4'h2;
    tick();
    tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (ovf_count !== 8'd0) begin
      errors++;
      $display("FAIL clear_wins: got ovf=%0d, required 0", ovf_count);
    end
    tick();
    ch_valid = 4'h0;
    checks++;
    if (ovf_count !== 8'd1) begin
      errors++;
      $display("FAIL count_after_clear: got ovf=%0d, required 1", ovf_count);
    end
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_drain: got valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_send();
    out_ready = 1'b0;
    set_lane(2, 16'h0222); set_lane(1, 16'h0111); ch_valid = 4'h6;
    tick();
    ch_valid = 4'h0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h80000222) begin
      errors++;
      $display("FAIL pre_reset_send: got valid=%b data=%h, required 1 80000222", out_valid, out_data);
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || ovf_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b data=%h ovf=%0d, required 0 0 0",
               out_valid, out_data, ovf_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_word%0d: got valid=%b data=%h, required valid 0", k, out_valid, out_data);
      end
    end
    set_lane(0, 16'h0042); ch_valid = 4'h1;
    tick();
    ch_valid = 4'h0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h00000042) begin
      errors++;
      $display("FAIL post_reset_word: got valid=%b data=%h, required 1 00000042", out_valid, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_all_lanes();
    test_backpressure();
    test_round_robin();
    test_sign_and_frame();
    test_disable_and_saturate();
    test_reset_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
